ecg_sample_uart_tx: RTL and testbench



---
 rtl/ecg_sample_uart_tx.sv | 149 ++++++++++++++
 tb/tb_ecg_sample_uart_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ecg_sample_uart_tx.sv
// ecg_sample_uart_tx
//   Captures each 12-bit ECG sample on the rising edge of the ADC data-valid
//   level, buffers it in a small FIFO and sends it to the host as a 3-byte
//   8N1 UART frame: A5, {4'h0, sample[11:8]}, sample[7:0], LSB first.
// Ports
//   clk, rst_n  system clock, asynchronous active-low reset
//   data [11:0] ADC sample, valid while dv is high
//   dv          data-valid level from the ADC master
//   tx          UART serial output, registered, idles high
//   busy        TX FSM not in IDLE
//   fifo_level  samples currently buffered
//   overflow    sticky, a sample was dropped because the FIFO was full
module ecg_sample_uart_tx #(
  parameter int unsigned FCLK       = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [11:0]                   data,
  input  logic                          dv,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int unsigned CLKS_PER_BIT = FCLK / BAUD;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   frame_q;
  logic [7:0]    cur_byte;
  logic          tx_q, tx_d;
  logic          dv_d;
  logic          overflow_q;
  logic [11:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, pop, push_req, push, baud_wrap;

  // Pointers carry one extra wrap bit so level = writes - reads covers 0..DEPTH.
  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = (fifo_level == LW'(FIFO_DEPTH));
  assign pop        = (state_q == IDLE) && (fifo_level != '0);
  assign push_req   = dv && !dv_d;
  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign push       = push_req && (!full || pop);
  assign baud_wrap  = (baud_q == BAUD_LAST);

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data;
  end

  // dv_d resets high so a dv already asserted at reset release is not a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_d       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      dv_d <= dv;
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + LW'(1);
        frame_q <= {8'hA5, 4'h0, mem[rd_ptr[AW-1:0]]};
      end
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = START;
        baud_d  = '0;
        byte_d  = '0;
      end
      START: if (baud_wrap) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
      end else baud_d = baud_q + CW'(1);
      DATA: if (baud_wrap) begin
        baud_d = '0;
        if (bit_q == 3'd7) state_d = STOP;
        else               bit_d   = bit_q + 3'd1;
      end else baud_d = baud_q + CW'(1);
      STOP: if (baud_wrap) begin
        baud_d = '0;
        if (byte_q != 2'd2) begin
          byte_d  = byte_q + 2'd1;
          state_d = START;
        end else state_d = IDLE;
      end else baud_d = baud_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end

  // FSM output: tx is computed from the next state so the register holds the
  // line level for the coming bit; it only moves on a baud wrap or state entry.
  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = frame_q[23:16];
      2'd1:    cur_byte = frame_q[15:8];
      default: cur_byte = frame_q[7:0];
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ecg_sample_uart_tx.sv
// tb_ecg_sample_uart_tx
//   Directed bench at CLKS_PER_BIT=10, FIFO_DEPTH=8. Frames are checked bit by
//   bit: every bit must hold its level (and busy) for exactly 10 clocks.
`timescale 1ns/1ps
module tb_ecg_sample_uart_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] data = '0;
  logic        dv = 1'b0;
  logic        tx, busy, overflow;
  logic [3:0]  fifo_level;

  int n_checks = 0;
  int n_pass   = 0;

  ecg_sample_uart_tx #(.FCLK(1_000_000), .BAUD(100_000), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dv(dv),
    .tx(tx), .busy(busy), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Entered at the sample point just after the pop edge (tx already low).
  task automatic expect_frame(input logic [11:0] s, input string tag);
    logic [7:0] b;
    logic [9:0] tv, bv;
    logic       e;
    for (int j = 0; j < 30; j++) begin
      case (j / 10)
        0:       b = 8'hA5;
        1:       b = {4'h0, s[11:8]};
        default: b = s[7:0];
      endcase
      case (j % 10)
        0:       e = 1'b0;
        9:       e = 1'b1;
        default: e = b[(j % 10) - 1];
      endcase
      for (int c = 0; c < 10; c++) begin
        tv[c] = tx;
        bv[c] = busy;
        tick(1);
      end
      chk({12'b0, tv, bv}, {12'b0, {10{e}}, 10'h3FF}, $sformatf("%s_bit%0d", tag, j));
    end
    chk({30'b0, tx, busy}, 32'h2, $sformatf("%s_end_idle", tag));
  endtask

  task automatic push_pulse(input logic [11:0] d);
    data = d;
    dv   = 1'b1;
    tick(1);
    dv   = 1'b0;
    tick(2);
  endtask

  initial begin
    logic saw;
    // reset state
    tick(3);
    chk(32'(tx), 32'h1, "rst_tx");
    chk(32'(busy), 32'h0, "rst_busy");
    chk(32'(fifo_level), 32'h0, "rst_level");
    chk(32'(overflow), 32'h0, "rst_overflow");
    rst_n = 1'b1;
    tick(2);

    // 1: single 50-clock pulse, sample ABC
    data = 12'hABC;
    dv   = 1'b1;
    tick(1);
    chk(32'(fifo_level), 32'h1, "t1_level_push");
    chk({30'b0, tx, busy}, 32'h2, "t1_tx_busy_push");
    tick(1);
    chk({30'b0, tx, busy}, 32'h1, "t1_tx_busy_pop");
    chk(32'(fifo_level), 32'h0, "t1_level_pop");
    fork
      begin tick(48); dv = 1'b0; end
      expect_frame(12'hABC, "t1");
    join
    chk(32'(fifo_level), 32'h0, "t1_level_end");
    chk(32'(overflow), 32'h0, "t1_overflow");
    tick(3);

    // 2: dv held high for 1000 clocks gives one frame only
    data = 12'h5A3;
    dv   = 1'b1;
    tick(1);
    chk(32'(fifo_level), 32'h1, "t2_level_push");
    tick(1);
    chk(32'(tx), 32'h0, "t2_start");
    expect_frame(12'h5A3, "t2");
    saw = 1'b0;
    repeat (698) begin
      saw = saw | busy | (fifo_level != 0);
      tick(1);
    end
    chk(32'(saw), 32'h0, "t2_no_second_frame");
    dv = 1'b0;
    tick(3);

    // 3: nine edges 3 clocks apart; first pops at once, eight buffer
    fork
      begin
        for (int i = 0; i < 9; i++) push_pulse(12'(i));
        chk(32'(fifo_level), 32'h8, "t3_level_full");
        chk(32'(overflow), 32'h0, "t3_no_overflow");
      end
      begin
        tick(2);
        chk(32'(tx), 32'h0, "t3_f0_start");
        expect_frame(12'h000, "t3_f0");
      end
    join
    chk(32'(fifo_level), 32'h8, "t3_level_f0_end");

    // 4: push on the same edge as the frame-end pop while full
    data = 12'h777;
    dv   = 1'b1;
    tick(1);
    dv   = 1'b0;
    chk(32'(fifo_level), 32'h8, "t4_level_same_edge");
    chk(32'(overflow), 32'h0, "t4_overflow_clear");
    chk(32'(tx), 32'h0, "t4_start");
    // 10th edge during the frame while level=8 is dropped
    fork
      begin
        tick(20);
        push_pulse(12'hDDD);
        chk(32'(overflow), 32'h1, "t3_overflow_set");
        chk(32'(fifo_level), 32'h8, "t3_level_after_drop");
      end
      expect_frame(12'h001, "t3_f1");
    join
    for (int s = 2; s <= 8; s++) begin
      tick(1);
      chk(32'(tx), 32'h0, $sformatf("t3_f%0d_start", s));
      expect_frame(12'(s), $sformatf("t3_f%0d", s));
    end
    tick(1);
    chk(32'(tx), 32'h0, "t4_last_start");
    expect_frame(12'h777, "t4_last");
    chk(32'(fifo_level), 32'h0, "t3_level_drained");
    chk(32'(overflow), 32'h1, "t3_overflow_sticky");
    tick(3);

    // 5: reset in the middle of byte1 DATA
    push_pulse(12'h3C5);
    push_pulse(12'h456);
    chk(32'(fifo_level), 32'h1, "t5_level_pre");
    tick(126);
    chk({30'b0, tx, busy}, 32'h1, "t5_byte1_bit2");
    rst_n = 1'b0;
    #1;
    chk(32'(tx), 32'h1, "t5_async_tx");
    chk(32'(busy), 32'h0, "t5_async_busy");
    chk(32'(fifo_level), 32'h0, "t5_async_level");
    chk(32'(overflow), 32'h0, "t5_async_overflow");
    dv = 1'b1;
    data = 12'h999;
    tick(3);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      tick(1);
      saw = saw | busy | ~tx | (fifo_level != 0);
    end
    chk(32'(saw), 32'h0, "t5_no_capture_high_dv");
    dv = 1'b0;
    tick(2);
    data = 12'h123;
    dv   = 1'b1;
    tick(1);
    chk(32'(fifo_level), 32'h1, "t5_level_new_edge");
    tick(1);
    dv = 1'b0;
    chk(32'(tx), 32'h0, "t5_start");
    expect_frame(12'h123, "t5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
